// File: rtl/gcn_coo_pkg.sv
// Shared types and sizing for the COO edge-memory fetch path.
package gcn_coo_pkg;

  localparam int unsigned COO_NUM_OF_COLS = 6;
  localparam int unsigned COO_NUM_OF_ROWS = 2;
  localparam int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS);
  localparam int unsigned COO_ROW_IDX     = 0;
  localparam int unsigned COO_COL_IDX     = 1;

  typedef struct packed {
    logic [COO_BW-1:0] row;
    logic [COO_BW-1:0] col;
  } coo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } coo_fetch_state_t;

  // Saturate an entry index to the last valid memory address.
  function automatic logic [COO_BW-1:0] clamp_addr(input logic [COO_BW:0] a);
    if (a > (COO_BW+1)'(COO_NUM_OF_COLS - 1)) begin
      return COO_BW'(COO_NUM_OF_COLS - 1);
    end
    return a[COO_BW-1:0];
  endfunction

endpackage

// File: rtl/coo_stream_fetch.sv
// Walks the COO edge memory and streams (row, col) entries with
// last-of-traversal and end-of-row tags to the aggregation stage.
module coo_stream_fetch
  import gcn_coo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COO_BW:0]   nnz,
  output logic [COO_BW-1:0] coo_address,
  input  logic [COO_BW-1:0] coo_in [COO_NUM_OF_ROWS],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COO_BW-1:0] out_row,
  output logic [COO_BW-1:0] out_col,
  output logic              out_last,
  output logic              out_row_end,
  output logic              busy,
  output logic              done
);

  coo_fetch_state_t  state_q, state_d;
  logic [COO_BW:0]   idx_q, idx_d;
  logic [COO_BW:0]   nnz_q, nnz_d;
  coo_entry_t        hold_q, hold_d;
  logic [COO_BW-1:0] addr_q, addr_d;
  logic              last_c;
  coo_entry_t        mem_entry_c;

  assign mem_entry_c.row = coo_in[COO_ROW_IDX];
  assign mem_entry_c.col = coo_in[COO_COL_IDX];

  // Outputs decode directly from registered state; row_end peeks at the
  // lookahead entry already sitting on coo_in.
  assign last_c      = (idx_q == (nnz_q - (COO_BW+1)'(1)));
  assign out_valid   = (state_q == STREAM);
  assign out_row     = hold_q.row;
  assign out_col     = hold_q.col;
  assign out_last    = out_valid && last_c;
  assign out_row_end = out_valid && (last_c || (mem_entry_c.row != hold_q.row));
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign coo_address = addr_q;

  // Next-state, index, hold and lookahead-address logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nnz_d   = nnz_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          if (nnz == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            nnz_d   = (nnz > (COO_BW+1)'(COO_NUM_OF_COLS)) ?
                      (COO_BW+1)'(COO_NUM_OF_COLS) : nnz;
          end
        end
      end
      LOAD: begin
        hold_d  = mem_entry_c;
        idx_d   = '0;
        addr_d  = clamp_addr((COO_BW+1)'(1));
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (last_c) begin
            state_d = DONE;
          end else begin
            hold_d = mem_entry_c;
            idx_d  = idx_q + (COO_BW+1)'(1);
            addr_d = clamp_addr(idx_q + (COO_BW+1)'(2));
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any traversal at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nnz_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nnz_q   <= nnz_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end

endmodule
